obj_serializer: RTL and testbench

Sequential, counter-based object pixel generator for the TIA video path. It is the parametrised successor to the combinational compare-based pixel test. Each instance keeps its own horizontal position counter, decodes copy-start points from the size code, and shifts the graphics register out at 1x/2x/4x stretch. Reset-position strobes and signed motion offsets are supported. The playfield/priority mixer instantiates one per player or missile and consumes `pixel_on`.

---
 rtl/obj_serializer.sv | 104 ++++++++++
 tb/tb_obj_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_serializer.sv
// obj_serializer: counter-based object pixel generator; define OBJ_VDEL_EN to add the delayed graphics register
module obj_serializer #(
    parameter int LINE_PIXELS  = 160,
    parameter int POS_WIDTH    = 8,
    parameter int GFX_WIDTH    = 8,
    parameter int COPY_SPACING = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 resp,
    input  logic                 mot_apply,
    input  logic [3:0]           motion,
    input  logic [2:0]           size,
    input  logic                 reflect,
    input  logic                 gfx_wr,
    input  logic [GFX_WIDTH-1:0] gfx_in,
    input  logic                 vdel,
    input  logic                 vdel_copy,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 pixel_on
);
    localparam int IDX_W = GFX_WIDTH > 1 ? $clog2(GFX_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GFX_WIDTH - 1);
    localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(LINE_PIXELS - 1);
    localparam logic [POS_WIDTH-1:0] OFF1 = POS_WIDTH'(COPY_SPACING);
    localparam logic [POS_WIDTH-1:0] OFF2 = POS_WIDTH'(2 * COPY_SPACING);
    localparam logic [POS_WIDTH-1:0] OFF4 = POS_WIDTH'(4 * COPY_SPACING);
    localparam logic signed [POS_WIDTH+1:0] LINE_S = (POS_WIDTH + 2)'(LINE_PIXELS);

    logic                        active;
    logic [IDX_W-1:0]            idx;
    logic [1:0]                  cnt;
    logic [1:0]                  cntLast;
    logic [GFX_WIDTH-1:0]        gfxNew;
    logic [GFX_WIDTH-1:0]        gfxSel;
    logic [POS_WIDTH-1:0]        nextPos;
    logic [POS_WIDTH-1:0]        movePos;
    logic signed [POS_WIDTH+1:0] mvSum;
    logic                        copyStart;
    logic                        bitSel;

`ifdef OBJ_VDEL_EN
    logic [GFX_WIDTH-1:0] gfxOld;
    // delayed copy takes the pre-write value of the new register
    always_ff @(posedge clk) begin
        if (rst) gfxOld <= '0;
        else if (vdel_copy) gfxOld <= gfxNew;
    end
    assign gfxSel = vdel ? gfxOld : gfxNew;
`else
    logic unusedVdel;
    assign unusedVdel = vdel ^ vdel_copy;
    assign gfxSel = gfxNew;
`endif

    // next counter value, copy-start decode, stretch modulus, motion wrap and output bit select
    always_comb begin
        nextPos = pos == LAST_POS ? '0 : pos + 1'b1;
        copyStart = nextPos == '0
                 || (size == 3'd1 || size == 3'd3) && nextPos == OFF1
                 || (size == 3'd2 || size == 3'd3 || size == 3'd6) && nextPos == OFF2
                 || (size == 3'd4 || size == 3'd6) && nextPos == OFF4;
        cntLast = size == 3'd7 ? 2'd3 : size == 3'd5 ? 2'd1 : 2'd0;
        mvSum = $signed({2'b00, pos}) + $signed({{(POS_WIDTH - 2){motion[3]}}, motion});
        movePos = mvSum[POS_WIDTH+1] ? POS_WIDTH'(mvSum + LINE_S)
                : mvSum >= LINE_S ? POS_WIDTH'(mvSum - LINE_S) : POS_WIDTH'(mvSum);
        bitSel = reflect ? gfxSel[idx] : gfxSel[LAST_IDX - idx];
    end

    // position counter, serializer and registered pixel; resp beats motion, motion beats pix_en
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
            pixel_on <= 1'b0;
            active <= 1'b0;
            idx <= '0;
            cnt <= '0;
            gfxNew <= '0;
        end else begin
            if (gfx_wr) gfxNew <= gfx_in;
            if (resp) begin
                pos <= '0;
                active <= 1'b0;
            end else if (mot_apply) begin
                pos <= movePos;
            end else if (pix_en) begin
                pos <= nextPos;
                pixel_on <= active && bitSel;
                if (copyStart) begin
                    active <= 1'b1;
                    idx <= '0;
                    cnt <= '0;
                end else if (active) begin
                    cnt <= cnt >= cntLast ? 2'd0 : cnt + 2'd1;
                    if (cnt >= cntLast) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) active <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_obj_serializer.sv
// tb_obj_serializer: directed and randomized checks of obj_serializer against a pixel-time reference model
module tb_obj_serializer;
    localparam int L = 160;
    localparam int W = 8;
    localparam int S = 16;

    logic clk = 1'b0;
    logic rst, pix_en, resp, mot_apply, reflect, gfx_wr, vdel, vdel_copy;
    logic [3:0] motion;
    logic [2:0] size;
    logic [7:0] gfx_in;
    logic [7:0] pos;
    logic pixel_on;

    int checks = 0;
    int fails = 0;

    int mPos, t, tStart;
    logic mPix;
    logic [7:0] mGfx, mOld;

    obj_serializer dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .resp(resp), .mot_apply(mot_apply),
        .motion(motion), .size(size), .reflect(reflect), .gfx_wr(gfx_wr), .gfx_in(gfx_in),
        .vdel(vdel), .vdel_copy(vdel_copy), .pos(pos), .pixel_on(pixel_on)
    );

    always #5 clk = ~clk;

    function automatic bit isStart(int p, int sz);
        case (sz)
            1: return p == 0 || p == S;
            2: return p == 0 || p == 2 * S;
            3: return p == 0 || p == S || p == 2 * S;
            4: return p == 0 || p == 4 * S;
            6: return p == 0 || p == 2 * S || p == 4 * S;
            default: return p == 0;
        endcase
    endfunction

    // pixel k of the current copy is bit k/stretch, counted in pix_en cycles since the start
    function automatic logic modelBit();
        int st, k;
        logic [7:0] g;
        st = size == 3'd7 ? 4 : size == 3'd5 ? 2 : 1;
        k = t - tStart;
        g = mGfx;
`ifdef OBJ_VDEL_EN
        if (vdel) g = mOld;
`endif
        if (tStart < 0 || k >= W * st) return 1'b0;
        return reflect ? g[k / st] : g[W - 1 - k / st];
    endfunction

    task automatic step(input logic pe, input logic rs, input logic ma, input logic [3:0] mo,
                        input logic gw, input logic [7:0] gi, input logic vc);
        pix_en = pe; resp = rs; mot_apply = ma; motion = mo; gfx_wr = gw; gfx_in = gi; vdel_copy = vc;
        @(posedge clk);
        #1;
        if (rs) begin
            mPos = 0;
            tStart = -1;
        end else if (ma) begin
            mPos = ((mPos + int'($signed(mo))) % L + L) % L;
        end else if (pe) begin
            mPix = modelBit();
            t++;
            mPos = (mPos + 1) % L;
            if (isStart(mPos, int'(size))) tStart = t;
        end
`ifdef OBJ_VDEL_EN
        if (vc) mOld = mGfx;
`endif
        if (gw) mGfx = gi;
    endtask

    task automatic pix();
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] g);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, g, 1'b0);
    endtask

    task automatic resetModel();
        mPos = 0; t = 0; tStart = -1; mPix = 1'b0; mGfx = '0; mOld = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_en = 0; resp = 0; mot_apply = 0; motion = 0; size = 0; reflect = 0;
        gfx_wr = 0; gfx_in = 0; vdel = 0; vdel_copy = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        checks++;
        if (pos !== 8'd0) begin fails++; $display("FAIL reset_pos got %0d want 0", pos); end
        checks++;
        if (pixel_on !== 1'b0) begin fails++; $display("FAIL reset_pix got %b want 0", pixel_on); end
    endtask

    task automatic test_wrap();
        logic ep;
        size = 3'd0; reflect = 1'b0;
        wr(8'hF0);
        for (int i = 1; i <= 170; i++) begin
            pix();
            ep = i > 160 && i - 160 <= 4;
            checks++;
            if (pos !== 8'(i % L) || pixel_on !== ep) begin
                fails++;
                $display("FAIL wrap i=%0d pos=%0d want %0d pix=%b want %b", i, pos, i % L, pixel_on, ep);
            end
        end
    endtask

    task automatic test_resp();
        logic ep;
        int p;
        repeat (27) pix();
        checks++;
        if (pos !== 8'd37) begin fails++; $display("FAIL resp_pre pos=%0d want 37", pos); end
        size = 3'd1;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        checks++;
        if (pos !== 8'd0) begin fails++; $display("FAIL resp_pos pos=%0d want 0", pos); end
        for (int i = 1; i <= 190; i++) begin
            pix();
            p = i % L;
            ep = (p >= 17 && p <= 20) || (i > 160 && p >= 1 && p <= 4);
            checks++;
            if (pos !== 8'(p) || pixel_on !== ep) begin
                fails++;
                $display("FAIL resp i=%0d pos=%0d want %0d pix=%b want %b", i, pos, p, pixel_on, ep);
            end
        end
    endtask

    task automatic test_stretch();
        logic ep;
        int p;
        wr(8'h81);
        size = 3'd7;
        for (int i = 1; i <= 170; i++) begin
            pix();
            p = i - 130;
            ep = i > 130 && ((p >= 1 && p <= 4) || (p >= 29 && p <= 32));
            checks++;
            if (pixel_on !== ep) begin
                fails++;
                $display("FAIL stretch i=%0d pos=%0d pix=%b want %b", i, pos, pixel_on, ep);
            end
        end
    endtask

    task automatic test_motion();
        size = 3'd0;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        repeat (3) pix();
        step(1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 8'd0, 1'b0);
        checks++;
        if (pos !== 8'd155) begin fails++; $display("FAIL motion_neg pos=%0d want 155", pos); end
        repeat (3) pix();
        step(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 8'd0, 1'b0);
        checks++;
        if (pos !== 8'd5) begin fails++; $display("FAIL motion_pos pos=%0d want 5", pos); end
        for (int i = 6; i <= 10; i++) begin
            pix();
            checks++;
            if (pos !== 8'(i) || pixel_on !== 1'b0) begin
                fails++;
                $display("FAIL motion_skip pos=%0d want %0d pix=%b want 0", pos, i, pixel_on);
            end
        end
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 8'd0, 1'b0);
        checks++;
        if (pos !== 8'd0) begin fails++; $display("FAIL motion_resp pos=%0d want 0", pos); end
    endtask

    task automatic test_triple();
        logic ep;
        size = 3'd6; reflect = 1'b1;
        wr(8'h01);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 230; i++) begin
            if (i == 200) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0);
            else pix();
            ep = i == 33 || i == 65 || i == 161 || i == 193;
            checks++;
            if (pos !== 8'(i % L) || pixel_on !== ep) begin
                fails++;
                $display("FAIL triple i=%0d pos=%0d want %0d pix=%b want %b", i, pos, i % L, pixel_on, ep);
            end
        end
        reflect = 1'b0;
    endtask

`ifdef OBJ_VDEL_EN
    task automatic test_vdel();
        logic ep;
        logic [7:0] a, b;
        int p;
        a = 8'hA5; b = 8'h3C;
        size = 3'd0; reflect = 1'b0; vdel = 1'b0;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
        wr(a);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b1);
        wr(b);
        for (int i = 1; i <= 330; i++) begin
            vdel = i <= 170;
            pix();
            p = i > 320 ? i - 320 : i - 160;
            ep = i > 160 && p >= 1 && p <= 8 && (i > 320 ? b[8 - p] : a[8 - p]);
            checks++;
            if (pixel_on !== ep) begin
                fails++;
                $display("FAIL vdel i=%0d pos=%0d pix=%b want %b", i, pos, pixel_on, ep);
            end
        end
        vdel = 1'b0;
    endtask
`endif

    task automatic test_rst_midcopy();
        size = 3'd0; reflect = 1'b0;
        wr(8'hFF);
        while (pos != 8'd2) pix();
        checks++;
        if (pixel_on !== 1'b1) begin fails++; $display("FAIL midcopy_pre pix=%b want 1", pixel_on); end
        rst = 1'b1; pix_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        checks++;
        if (pixel_on !== 1'b0 || pos !== 8'd0) begin
            fails++;
            $display("FAIL midcopy_rst pix=%b want 0 pos=%0d want 0", pixel_on, pos);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 8; seg++) begin
            size = 3'($urandom_range(0, 7));
            reflect = 1'($urandom);
            step(1'b0, 1'b1, 1'b0, 4'd0, 1'($urandom), 8'($urandom), 1'b0);
            for (int n = $urandom_range(200, 400); n > 0; n--) begin
                if ($urandom_range(0, 19) == 0) reflect = ~reflect;
`ifdef OBJ_VDEL_EN
                if ($urandom_range(0, 19) == 0) vdel = ~vdel;
`endif
                step($urandom_range(0, 9) < 8, 1'b0, $urandom_range(0, 29) == 0, 4'($urandom),
                     $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 19) == 0);
                checks++;
                if (pos !== 8'(mPos) || pixel_on !== mPix) begin
                    fails++;
                    $display("FAIL random seg=%0d size=%0d pos=%0d want %0d pix=%b want %b",
                             seg, size, pos, mPos, pixel_on, mPix);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_resp();
        test_stretch();
        test_motion();
        test_triple();
`ifdef OBJ_VDEL_EN
        test_vdel();
`endif
        test_rst_midcopy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
